pc_ch_switch_ctrl: RTL and testbench

//   Sequences changes of the PC channel mode (remote UART(0) / UDP(1)) for the PC channel mux.
//   A mode change is applied only after traffic has been quiet for IDLE_GAP cycles, so no byte

---
 rtl/pc_ch_switch_ctrl_if.sv | 42 ++++
 rtl/pc_ch_switch_ctrl.sv | 141 ++++++++++++++
 tb/tb_pc_ch_switch_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_ch_switch_ctrl_if.sv
// Bundles the mode request, channel activity and switch status signals of the
// PC channel switch controller.
interface pc_ch_switch_ctrl_if;
    logic mode_req;
    logic pc_tx_data_valid;
    logic pc_rmrx_data_valid;
    logic udp_rx_data_valid;
    logic pc_ch_mode;
    logic sw_busy;
    logic tx_block;
    logic rx_blank;
    logic sw_done;
    logic sw_forced;

    // Side that requests mode changes and observes switch status
    modport master (
        output mode_req,
        output pc_tx_data_valid,
        output pc_rmrx_data_valid,
        output udp_rx_data_valid,
        input  pc_ch_mode,
        input  sw_busy,
        input  tx_block,
        input  rx_blank,
        input  sw_done,
        input  sw_forced
    );

    // Switch controller side
    modport slave (
        input  mode_req,
        input  pc_tx_data_valid,
        input  pc_rmrx_data_valid,
        input  udp_rx_data_valid,
        output pc_ch_mode,
        output sw_busy,
        output tx_block,
        output rx_blank,
        output sw_done,
        output sw_forced
    );
endinterface

// File: rtl/pc_ch_switch_ctrl.sv
// PC channel mode switch sequencer. A requested mode change waits for the
// active channel to go quiet for IDLE_GAP cycles (or is forced after MAX_WAIT
// cycles), is applied for one SWITCH cycle, and is followed by a GUARD window
// that blocks TX and blanks RX so mux pipeline residue is discarded.
module pc_ch_switch_ctrl #(
    parameter logic RST_MODE  = 1'b0,
    parameter int   CNT_W     = 16,
    parameter int   IDLE_GAP  = 16,
    parameter int   GUARD_CYC = 8,
    parameter int   MAX_WAIT  = 65535
) (
    input  logic                 clk_sys,
    input  logic                 rst,
    pc_ch_switch_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_STABLE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2,
        ST_GUARD  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IDLE_GAP - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(MAX_WAIT - 1);

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   gap_cnt_q,   gap_cnt_d;
    logic [CNT_W-1:0]   wait_cnt_q,  wait_cnt_d;
    logic [CNT_W-1:0]   guard_cnt_q, guard_cnt_d;
    logic               forced_q,    forced_d;
    logic               mode_q,      mode_d;
    logic               busy_q,      busy_d;
    logic               block_q,     block_d;
    logic               done_q,      done_d;
    logic               fpulse_q,    fpulse_d;
    logic               act;

    // Counters stop at all-ones rather than wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Only the RX source of the currently applied mode counts as activity
    assign act = bus.pc_tx_data_valid |
                 (mode_q ? bus.udp_rx_data_valid : bus.pc_rmrx_data_valid);

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        guard_cnt_d = guard_cnt_q;
        forced_d    = forced_q;
        mode_d      = mode_q;
        done_d      = 1'b0;
        fpulse_d    = 1'b0;

        case (state_q)
            ST_STABLE: begin
                gap_cnt_d  = '0;
                wait_cnt_d = '0;
                if (bus.mode_req != mode_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                wait_cnt_d = sat_inc(wait_cnt_q);
                gap_cnt_d  = act ? '0 : sat_inc(gap_cnt_q);
                // A withdrawn request wins over any pending switch
                if (bus.mode_req == mode_q) begin
                    state_d = ST_STABLE;
                end else if (!act && (gap_cnt_q == GAP_LAST)) begin
                    state_d  = ST_SWITCH;
                    forced_d = 1'b0;
                    mode_d   = bus.mode_req;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d  = ST_SWITCH;
                    forced_d = 1'b1;
                    mode_d   = bus.mode_req;
                end
            end
            ST_SWITCH: begin
                state_d     = ST_GUARD;
                guard_cnt_d = '0;
            end
            ST_GUARD: begin
                if (guard_cnt_q == GUARD_LAST) begin
                    state_d  = ST_STABLE;
                    done_d   = 1'b1;
                    fpulse_d = forced_q;
                end else begin
                    guard_cnt_d = sat_inc(guard_cnt_q);
                end
            end
            default: begin
                state_d = ST_STABLE;
            end
        endcase

        busy_d  = (state_d != ST_STABLE);
        block_d = (state_d == ST_SWITCH) || (state_d == ST_GUARD);
    end

    // State, counters and outputs, cleared asynchronously by rst
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q     <= ST_STABLE;
            gap_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            guard_cnt_q <= '0;
            forced_q    <= 1'b0;
            mode_q      <= RST_MODE;
            busy_q      <= 1'b0;
            block_q     <= 1'b0;
            done_q      <= 1'b0;
            fpulse_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            forced_q    <= forced_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            block_q     <= block_d;
            done_q      <= done_d;
            fpulse_q    <= fpulse_d;
        end
    end

    assign bus.pc_ch_mode = mode_q;
    assign bus.sw_busy    = busy_q;
    assign bus.tx_block   = block_q;
    assign bus.rx_blank   = block_q;
    assign bus.sw_done    = done_q;
    assign bus.sw_forced  = fpulse_q;

endmodule

// File: tb/tb_pc_ch_switch_ctrl.sv
// Testbench for pc_ch_switch_ctrl: vector table, directed multi-cycle
// sequences and randomized traffic against a behavioural model.
module tb_pc_ch_switch_ctrl;

    localparam int IDLE_GAP  = 16;
    localparam int GUARD_CYC = 8;
    localparam int MAX_WAIT  = 100;

    logic clk_sys;
    logic rst;
    int   checks;
    int   failures;

    pc_ch_switch_ctrl_if bus();

    pc_ch_switch_ctrl #(
        .RST_MODE  (1'b0),
        .CNT_W     (16),
        .IDLE_GAP  (IDLE_GAP),
        .GUARD_CYC (GUARD_CYC),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .bus     (bus)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // ---------------- behavioural model ----------------
    // Tracks: applied mode, whether a request is draining, the current quiet
    // run and total wait, and how many blanking cycles remain.
    logic m_mode;
    logic m_drain;
    int   m_quiet;
    int   m_waited;
    int   m_blank;
    logic m_forced_sw;
    logic m_done;
    logic m_fp;

    task automatic model_reset();
        m_mode = 1'b0; m_drain = 1'b0; m_quiet = 0; m_waited = 0;
        m_blank = 0; m_forced_sw = 1'b0; m_done = 1'b0; m_fp = 1'b0;
    endtask

    task automatic model_switch(input logic forced);
        m_mode      = bus.mode_req;
        m_drain     = 1'b0;
        m_blank     = GUARD_CYC + 1;
        m_forced_sw = forced;
    endtask

    task automatic model_step();
        logic a;
        if (rst) begin
            model_reset();
            return;
        end
        m_done = 1'b0;
        m_fp   = 1'b0;
        a = bus.pc_tx_data_valid | (m_mode ? bus.udp_rx_data_valid : bus.pc_rmrx_data_valid);
        if (m_blank > 0) begin
            m_blank--;
            if (m_blank == 0) begin
                m_done = 1'b1;
                m_fp   = m_forced_sw;
            end
        end else if (!m_drain) begin
            if (bus.mode_req != m_mode) begin
                m_drain = 1'b1; m_quiet = 0; m_waited = 0;
            end
        end else if (bus.mode_req == m_mode) begin
            m_drain = 1'b0;
        end else begin
            m_waited++;
            m_quiet = a ? 0 : m_quiet + 1;
            if (m_quiet >= IDLE_GAP)      model_switch(1'b0);
            else if (m_waited >= MAX_WAIT) model_switch(1'b1);
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_mode, input logic e_busy,
                            input logic e_block, input logic e_done, input logic e_forced);
        chk({tag, "_mode"},   bus.pc_ch_mode, e_mode);
        chk({tag, "_busy"},   bus.sw_busy,    e_busy);
        chk({tag, "_txblk"},  bus.tx_block,   e_block);
        chk({tag, "_rxblk"},  bus.rx_blank,   e_block);
        chk({tag, "_done"},   bus.sw_done,    e_done);
        chk({tag, "_forced"}, bus.sw_forced,  e_forced);
    endtask

    task automatic compare_model(input string tag);
        chk_outs(tag, m_mode, m_drain || (m_blank > 0), m_blank > 0, m_done, m_fp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_step();
        #1;
    endtask

    task automatic clear_valids();
        bus.pc_tx_data_valid   = 1'b0;
        bus.pc_rmrx_data_valid = 1'b0;
        bus.udp_rx_data_valid  = 1'b0;
    endtask

    // Drives an activity pattern from the request edge until sw_done or limit.
    // pat: 0 quiet, 1 remote RX 4-on/4-off, 2 TX for first 40 cycles, 3 remote RX held
    task automatic run_switch(input int pat, input int limit, output int flip_e,
                              output int done_e, output logic forced_at, output logic busy_ok);
        logic start_mode;
        start_mode = bus.pc_ch_mode;
        flip_e = -1; done_e = -1; forced_at = 1'b0; busy_ok = 1'b1;
        for (int k = 0; k < limit; k++) begin
            bus.pc_tx_data_valid   = (pat == 2) && (k < 40);
            bus.pc_rmrx_data_valid = (pat == 1) ? (((k / 4) % 2) == 0) : (pat == 3);
            tick();
            if (flip_e < 0 && bus.pc_ch_mode != start_mode) flip_e = k;
            if (bus.sw_done) begin
                done_e    = k;
                forced_at = bus.sw_forced;
                break;
            end
            if (!bus.sw_busy) busy_ok = 1'b0;
        end
        clear_valids();
    endtask

    function automatic logic rnd_valid(input int d);
        case (d)
            0:       return 1'b0;
            1:       return $urandom_range(0, 19) == 0;
            2:       return $urandom_range(0, 3) == 0;
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic req, tx, rm, udp;
        logic e_mode, e_busy, e_block, e_done, e_forced;
    } vec_t;

    vec_t vt[$];

    task automatic add_vec(input logic req, input logic tx, input logic rm, input logic udp,
                           input logic e_mode, input logic e_busy, input logic e_block,
                           input logic e_done, input logic e_forced);
        vec_t v;
        v.req = req; v.tx = tx; v.rm = rm; v.udp = udp;
        v.e_mode = e_mode; v.e_busy = e_busy; v.e_block = e_block;
        v.e_done = e_done; v.e_forced = e_forced;
        vt.push_back(v);
    endtask

    initial begin
        int   flip_e, done_e, cnt_done, cnt_blk, dens;
        logic forced_at, busy_ok;

        checks = 0; failures = 0;

        // Quiet 0->1 switch: DRAIN at edge 0, SWITCH at edge 16, blanking for
        // edges 16..24, sw_done after edge 25.
        for (int k = 0; k < 30; k++)
            add_vec(1'b1, 1'b0, 1'b0, 1'b0, k >= 16, k <= 24, (k >= 16) && (k <= 24), k == 25, 1'b0);
        // Abort: request 1->0 for five DRAIN cycles, then withdrawn.
        for (int j = 0; j < 5; j++)
            add_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++)
            add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        rst = 1'b1;
        bus.mode_req = 1'b0;
        clear_valids();
        model_reset();
        #1;
        chk_outs("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk_outs("rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_outs("rst_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Table-driven vectors
        for (int i = 0; i < vt.size(); i++) begin
            bus.mode_req           = vt[i].req;
            bus.pc_tx_data_valid   = vt[i].tx;
            bus.pc_rmrx_data_valid = vt[i].rm;
            bus.udp_rx_data_valid  = vt[i].udp;
            tick();
            chk_outs($sformatf("vec%0d", i), vt[i].e_mode, vt[i].e_busy,
                     vt[i].e_block, vt[i].e_done, vt[i].e_forced);
        end
        clear_valids();
        repeat (3) tick();

        // Channel-aware activity: mode 1 (UDP), remote RX activity is ignored
        bus.mode_req = 1'b0;
        run_switch(3, 200, flip_e, done_e, forced_at, busy_ok);
        chk_int("chaware_flip_edge", flip_e, 16);
        chk_int("chaware_done_edge", done_e, 16 + 1 + GUARD_CYC);
        chk("chaware_forced", forced_at, 1'b0);
        chk("chaware_busy", busy_ok, 1'b1);
        chk("chaware_mode", bus.pc_ch_mode, 1'b0);
        repeat (3) tick();

        // Forced: remote RX 4-on/4-off never leaves 16 quiet cycles
        bus.mode_req = 1'b1;
        run_switch(1, 300, flip_e, done_e, forced_at, busy_ok);
        chk_int("forced_flip_edge", flip_e, MAX_WAIT);
        chk_int("forced_done_edge", done_e, MAX_WAIT + 1 + GUARD_CYC);
        chk("forced_pulse", forced_at, 1'b1);
        chk("forced_busy", busy_ok, 1'b1);
        tick();
        chk("forced_pulse_clear", bus.sw_forced, 1'b0);
        chk("forced_done_clear", bus.sw_done, 1'b0);
        repeat (3) tick();

        // Burst defers: 40 cycles of TX, switch 16 idle cycles after the last
        bus.mode_req = 1'b0;
        run_switch(2, 300, flip_e, done_e, forced_at, busy_ok);
        chk_int("burst_flip_edge", flip_e, 40 + IDLE_GAP - 1);
        chk_int("burst_done_edge", done_e, 40 + IDLE_GAP + GUARD_CYC);
        chk("burst_forced", forced_at, 1'b0);
        chk("burst_busy", busy_ok, 1'b1);
        repeat (3) tick();

        // Reset mid-GUARD
        bus.mode_req = 1'b1;
        repeat (18) tick();
        chk("midguard_in_guard", bus.tx_block, 1'b1);
        chk("midguard_mode_before", bus.pc_ch_mode, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_outs("midguard_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.mode_req = 1'b0;
        tick();
        rst = 1'b0;
        cnt_done = 0; cnt_blk = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.sw_done)  cnt_done++;
            if (bus.tx_block) cnt_blk++;
        end
        chk_int("midguard_no_done", cnt_done, 0);
        chk_int("midguard_no_block", cnt_blk, 0);
        chk("midguard_mode_after", bus.pc_ch_mode, 1'b0);

        // Randomized traffic against the model
        dens = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) dens = $urandom_range(0, 3);
            if ($urandom_range(0, 59) == 0) bus.mode_req = ~bus.mode_req;
            bus.pc_tx_data_valid   = rnd_valid(dens);
            bus.pc_rmrx_data_valid = rnd_valid(dens);
            bus.udp_rx_data_valid  = rnd_valid(dens);
            rst = ($urandom_range(0, 999) == 0);
            tick();
            compare_model("rand");
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
